reaction_timer: RTL and testbench

- Responder side of the game's delay/stimulus path.
- Arms the delay counter via DelayEnable and waits for its Done pulse/level as the stimulus.
- On stimulus, lights the player LED and counts clock cycles until the player's button press is recognised.
- Reports the reaction time, or flags a false start if the button is pressed before the stimulus.

---
 rtl/reaction_timer_pkg.sv | 14 +
 rtl/reaction_timer_button_sync_edge.sv | 36 +++
 rtl/reaction_timer.sv | 139 +++++++++++++
 tb/tb_reaction_timer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/reaction_timer_pkg.sv
// Shared definitions for the reaction timer: state encoding and default
// counter width.
package reaction_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        MEASURE = 2'b10,
        RESULT  = 2'b11
    } state_t;

    localparam int DEFAULT_WIDTH = 11;

endpackage

// File: rtl/reaction_timer_button_sync_edge.sv
// Player button conditioning: two-flop synchroniser followed by a
// rising-edge detector, giving a one-cycle Press per button press.
module button_sync_edge (
    input  logic ClockIn,
    input  logic CLRN,
    input  logic Button,
    output logic Press
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    // Shift the raw button through the synchroniser and keep the previous value.
    always_comb begin
        sync1_d = Button;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchroniser and edge-history registers.
    always_ff @(posedge ClockIn or negedge CLRN) begin
        if (!CLRN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign Press = sync2_q & ~prev_q;

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer responder: arms the delay counter, lights the LED on its
// Done, counts cycles until the player presses, and reports the time or a
// false start. Optional best-time tracking is enabled with the macro
// REACTION_BEST_TIME_EN; without it BestTime is a constant all-ones.
module reaction_timer
    import reaction_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             ClockIn,
    input  logic             CLRN,
    input  logic             Start,
    input  logic             Stimulus,
    input  logic             Button,
    output logic             DelayEnable,
    output logic             Light,
    output logic [WIDTH-1:0] Time,
    output logic             Valid,
    output logic             FalseStart,
    output logic             Overflow,
    output logic [WIDTH-1:0] BestTime
);

    localparam logic [WIDTH-1:0] TIME_MAX = {WIDTH{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] time_q, time_d;
    logic             valid_q, valid_d;
    logic             false_start_q, false_start_d;
    logic             overflow_q, overflow_d;
    logic             press;

    button_sync_edge u_button (
        .ClockIn (ClockIn),
        .CLRN    (CLRN),
        .Button  (Button),
        .Press   (press)
    );

    // Round sequencing and the saturating reaction-time counter.
    always_comb begin
        state_d       = state_q;
        time_d        = time_q;
        valid_d       = valid_q;
        false_start_d = false_start_q;
        overflow_d    = overflow_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d       = ARMED;
                    time_d        = '0;
                    valid_d       = 1'b0;
                    false_start_d = 1'b0;
                    overflow_d    = 1'b0;
                end
            end
            ARMED: begin
                if (press) begin
                    state_d       = RESULT;
                    false_start_d = 1'b1;
                    valid_d       = 1'b0;
                    time_d        = '0;
                end else if (Stimulus) begin
                    state_d = MEASURE;
                    time_d  = '0;
                end
            end
            MEASURE: begin
                if (press) begin
                    state_d = RESULT;
                    valid_d = 1'b1;
                end else if (time_q != TIME_MAX) begin
                    time_d     = time_q + 1'b1;
                    overflow_d = overflow_q | (time_d == TIME_MAX);
                end
            end
            RESULT: begin
                if (Start) begin
                    state_d       = ARMED;
                    time_d        = '0;
                    valid_d       = 1'b0;
                    false_start_d = 1'b0;
                    overflow_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Round state and result registers.
    always_ff @(posedge ClockIn or negedge CLRN) begin
        if (!CLRN) begin
            state_q       <= IDLE;
            time_q        <= '0;
            valid_q       <= 1'b0;
            false_start_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            time_q        <= time_d;
            valid_q       <= valid_d;
            false_start_q <= false_start_d;
            overflow_q    <= overflow_d;
        end
    end

`ifdef REACTION_BEST_TIME_EN
    logic [WIDTH-1:0] best_q, best_d;

    // Capture a new record when a genuine, non-saturated round finishes faster.
    always_comb begin
        best_d = best_q;
        if (state_q == MEASURE && press && !overflow_q && time_q < best_q) begin
            best_d = time_q;
        end
    end

    // Best-time register, cleared to all ones only by reset.
    always_ff @(posedge ClockIn or negedge CLRN) begin
        if (!CLRN) begin
            best_q <= TIME_MAX;
        end else begin
            best_q <= best_d;
        end
    end

    assign BestTime = best_q;
`else
    assign BestTime = TIME_MAX;
`endif

    assign DelayEnable = (state_q == ARMED);
    assign Light       = (state_q == MEASURE);
    assign Time        = time_q;
    assign Valid       = valid_q;
    assign FalseStart  = false_start_q;
    assign Overflow    = overflow_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer: a table of per-cycle vectors plus
// hand-written rounds for reset, best time and saturation. Expected outputs
// are queued when inputs are driven and compared after the clock edge.
module tb_reaction_timer;

    localparam int W = 11;
    localparam logic [W-1:0] MAXT = {W{1'b1}};

    logic          clk = 1'b0;
    logic          CLRN = 1'b0;
    logic          Start = 1'b0;
    logic          Stimulus = 1'b0;
    logic          Button = 1'b0;
    logic          DelayEnable, Light, Valid, FalseStart, Overflow;
    logic [W-1:0]  Time, BestTime;

    reaction_timer #(.WIDTH(W)) dut (
        .ClockIn     (clk),
        .CLRN        (CLRN),
        .Start       (Start),
        .Stimulus    (Stimulus),
        .Button      (Button),
        .DelayEnable (DelayEnable),
        .Light       (Light),
        .Time        (Time),
        .Valid       (Valid),
        .FalseStart  (FalseStart),
        .Overflow    (Overflow),
        .BestTime    (BestTime)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         de, light, valid, fs, ovf;
        logic [W-1:0] tm;
        logic [W-1:0] best;
    } exp_t;

    typedef struct {
        logic         start, stim, btn, de, light, valid, fs;
        logic [W-1:0] tm;
    } vec_t;

    exp_t         sb[$];
    vec_t         tbl[$];
    int           checks = 0;
    int           fails = 0;
    logic [W-1:0] best_exp = '1;
    logic         prev_valid_exp = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = sb.pop_front();
            cmp("DelayEnable", 32'(DelayEnable), 32'(e.de));
            cmp("Light",       32'(Light),       32'(e.light));
            cmp("Valid",       32'(Valid),       32'(e.valid));
            cmp("FalseStart",  32'(FalseStart),  32'(e.fs));
            cmp("Overflow",    32'(Overflow),    32'(e.ovf));
            cmp("Time",        32'(Time),        32'(e.tm));
            cmp("BestTime",    32'(BestTime),    32'(e.best));
        end
    endtask

    task automatic applyStimulus(input int st, input int sm, input int bt, input int de,
                                 input int li, input int va, input int fs, input int ov,
                                 input int tm);
        exp_t e;
        logic [W-1:0] t;
        t = tm[W-1:0];
        @(negedge clk);
        Start    = st[0];
        Stimulus = sm[0];
        Button   = bt[0];
`ifdef REACTION_BEST_TIME_EN
        if (va[0] && !prev_valid_exp && !ov[0] && t < best_exp) best_exp = t;
`endif
        prev_valid_exp = va[0];
        e.de = de[0]; e.light = li[0]; e.valid = va[0]; e.fs = fs[0];
        e.ovf = ov[0]; e.tm = t; e.best = best_exp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic addVec(input int st, input int sm, input int bt, input int de,
                          input int li, input int va, input int fs, input int tm);
        vec_t v;
        v.start = st[0]; v.stim = sm[0]; v.btn = bt[0]; v.de = de[0];
        v.light = li[0]; v.valid = va[0]; v.fs = fs[0]; v.tm = tm[W-1:0];
        tbl.push_back(v);
    endtask

    task automatic checkAllZero(input string tag);
        cmp({tag, " DelayEnable"}, 32'(DelayEnable), 32'd0);
        cmp({tag, " Light"},       32'(Light),       32'd0);
        cmp({tag, " Valid"},       32'(Valid),       32'd0);
        cmp({tag, " FalseStart"},  32'(FalseStart),  32'd0);
        cmp({tag, " Overflow"},    32'(Overflow),    32'd0);
        cmp({tag, " Time"},        32'(Time),        32'd0);
        cmp({tag, " BestTime"},    32'(BestTime),    32'(MAXT));
    endtask

    // One genuine round whose recorded time is n (n >= 2), then button released.
    task automatic runRound(input int n);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 0);
        for (int j = 1; j <= n - 2; j++) applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, j);
        applyStimulus(0, 0, 1, 0, 1, 0, 0, 0, n - 1);
        applyStimulus(0, 0, 1, 0, 1, 0, 0, 0, n);
        applyStimulus(0, 0, 1, 0, 0, 1, 0, 0, n);
        for (int j = 0; j < 3; j++) applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, n);
    endtask

    initial begin
        // IDLE ignores Stimulus and Press
        addVec(0,1,1, 0,0,0,0,0); addVec(0,0,1, 0,0,0,0,0); addVec(0,0,1, 0,0,0,0,0);
        addVec(0,0,0, 0,0,0,0,0); addVec(0,0,0, 0,0,0,0,0);
        // normal round, Time=2
        addVec(1,0,0, 1,0,0,0,0); addVec(0,0,0, 1,0,0,0,0); addVec(0,1,0, 0,1,0,0,0);
        addVec(0,0,1, 0,1,0,0,1); addVec(0,1,1, 0,1,0,0,2); addVec(0,0,1, 0,0,1,0,2);
        addVec(0,0,1, 0,0,1,0,2); addVec(0,0,0, 0,0,1,0,2); addVec(0,0,0, 0,0,1,0,2);
        // false start during ARMED
        addVec(1,0,0, 1,0,0,0,0);
        for (int i = 0; i < 4; i++) addVec(0,0,0, 1,0,0,0,0);
        addVec(0,0,1, 1,0,0,0,0); addVec(0,0,1, 1,0,0,0,0); addVec(0,0,1, 0,0,0,1,0);
        addVec(0,1,0, 0,0,0,1,0); addVec(0,0,0, 0,0,0,1,0);
        // Press and Stimulus together: false start wins
        addVec(1,0,0, 1,0,0,0,0); addVec(0,0,1, 1,0,0,0,0); addVec(0,0,1, 1,0,0,0,0);
        addVec(0,1,1, 0,0,0,1,0); addVec(0,1,1, 0,0,0,1,0); addVec(0,0,0, 0,0,0,1,0);
        addVec(0,0,0, 0,0,0,1,0);
        // Start held high re-arms right after RESULT
        addVec(1,0,0, 1,0,0,0,0); addVec(1,1,0, 0,1,0,0,0); addVec(1,0,1, 0,1,0,0,1);
        addVec(1,0,1, 0,1,0,0,2); addVec(1,0,1, 0,0,1,0,2); addVec(1,0,1, 1,0,0,0,0);
        addVec(0,0,0, 1,0,0,0,0); addVec(0,0,0, 1,0,0,0,0); addVec(0,0,0, 1,0,0,0,0);
        // Press in the first MEASURE cycle gives Time=0
        addVec(0,0,1, 1,0,0,0,0); addVec(0,1,1, 0,1,0,0,0); addVec(0,0,1, 0,0,1,0,0);
        addVec(0,0,0, 0,0,1,0,0); addVec(0,0,0, 0,0,1,0,0);

        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        CLRN = 1'b1;

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].start, tbl[i].stim, tbl[i].btn, tbl[i].de,
                          tbl[i].light, tbl[i].valid, tbl[i].fs, 0, tbl[i].tm);
        end

        // reset mid-MEASURE at Time=37 aborts the round
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 0);
        for (int j = 1; j <= 37; j++) applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, j);
        @(negedge clk);
        CLRN = 1'b0;
        #1;
        checkAllZero("async reset");
        @(negedge clk);
        CLRN = 1'b1;
        prev_valid_exp = 1'b0;
        best_exp = '1;
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // best-time rounds, then a false start that must not disturb it
        runRound(40);
        runRound(25);
        runRound(30);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 1, 0, 0);
        for (int j = 0; j < 3; j++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);

        // saturation: Time sticks at the maximum and Overflow latches
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 0);
        for (int j = 1; j <= int'(MAXT) + 5; j++) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 0, (j >= int'(MAXT)) ? 1 : 0,
                          (j >= int'(MAXT)) ? int'(MAXT) : j);
        end
        applyStimulus(0, 0, 1, 0, 1, 0, 0, 1, int'(MAXT));
        applyStimulus(0, 0, 1, 0, 1, 0, 0, 1, int'(MAXT));
        applyStimulus(0, 0, 1, 0, 0, 1, 0, 1, int'(MAXT));
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, int'(MAXT));
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
